aes_shares_io_buffer: RTL and testbench

Share-level I/O adapter for the 32-bit masked AES core. Collects a masked plaintext block as four column beats of 32*d share bits and presents it as one 128*d-bit block to the state datapath's plaintext load (init) path. It also captures the 128*d-bit ciphertext from the state register and returns it as four column beats. Shares are only stored and routed, never recombined.

---
 rtl/aes_shares_io_buffer.sv | 142 ++++++++++++++
 tb/tb_aes_shares_io_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shares_io_buffer.sv
// Share-level beat<->block adapter for the masked AES core: four 32*d-bit beats in, one 128*d-bit block out, and back.
// Optional macro AES_IO_PT_PREFETCH_EN adds a fill buffer ahead of the plaintext buffer.
module aes_shares_io_buffer #(
    parameter int d = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [32*d-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [128*d-1:0]  pt_data,
    output logic              pt_valid,
    input  logic              pt_ready,
    input  logic [128*d-1:0]  ct_data,
    input  logic              ct_capture,
    output logic              ct_busy,
    output logic              ct_overrun,
    output logic [32*d-1:0]   out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int BW = 32*d;
    localparam int KW = 128*d;

    typedef enum logic {FILL, FULL} in_state_t;
    typedef enum logic {IDLE, SEND} out_state_t;

    in_state_t     r_in_state, w_in_next;
    out_state_t    r_out_state, w_out_next;
    logic [1:0]    r_ic, r_oc;
    logic [KW-1:0] r_pt, r_ct;
    logic          r_ovr;
    logic          w_in_acc, w_pt_hs, w_out_hs, w_cap;

    assign in_ready = !rst && (r_in_state == FILL);
    assign w_in_acc = in_valid && in_ready;
    assign w_pt_hs  = pt_valid && pt_ready;
    assign pt_data  = r_pt;

`ifdef AES_IO_PT_PREFETCH_EN
    logic [KW-1:0] r_fill;
    logic          r_pt_valid;
    logic          w_xfer;

    // FULL here means the fill buffer is full; it drains into r_pt when that slot frees up
    assign w_xfer   = (r_in_state == FULL) && (!r_pt_valid || pt_ready);
    assign pt_valid = r_pt_valid;

    always_comb begin
        w_in_next = r_in_state;
        case (r_in_state)
            FILL:    if (w_in_acc && r_ic == 2'd3) w_in_next = FULL;
            FULL:    if (w_xfer) w_in_next = FILL;
            default: w_in_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state <= FILL;
            r_ic       <= '0;
            r_fill     <= '0;
            r_pt       <= '0;
            r_pt_valid <= 1'b0;
        end else begin
            r_in_state <= w_in_next;
            if (w_in_acc) begin
                r_fill[r_ic*BW +: BW] <= in_data;
                r_ic                  <= r_ic + 2'd1;
            end
            if (w_xfer) begin
                r_pt       <= r_fill;
                r_pt_valid <= 1'b1;
            end else if (w_pt_hs) begin
                r_pt_valid <= 1'b0;
            end
        end
    end
`else
    assign pt_valid = (r_in_state == FULL);

    always_comb begin
        w_in_next = r_in_state;
        case (r_in_state)
            FILL:    if (w_in_acc && r_ic == 2'd3) w_in_next = FULL;
            FULL:    if (w_pt_hs) w_in_next = FILL;
            default: w_in_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state <= FILL;
            r_ic       <= '0;
            r_pt       <= '0;
        end else begin
            r_in_state <= w_in_next;
            if (w_in_acc) begin
                r_pt[r_ic*BW +: BW] <= in_data;
                r_ic                <= r_ic + 2'd1;
            end
        end
    end
`endif

    assign ct_busy    = (r_out_state == SEND);
    assign out_valid  = ct_busy;
    assign out_data   = r_ct[BW-1:0];
    assign ct_overrun = r_ovr;
    assign w_out_hs   = out_valid && out_ready;
    assign w_cap      = ct_capture && (r_out_state == IDLE);

    always_comb begin
        w_out_next = r_out_state;
        case (r_out_state)
            IDLE:    if (ct_capture) w_out_next = SEND;
            SEND:    if (w_out_hs && r_oc == 2'd3) w_out_next = IDLE;
            default: w_out_next = IDLE;
        endcase
    end

    // The block is shifted down one beat per handshake so out_data is always a fixed register slice
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_state <= IDLE;
            r_oc        <= '0;
            r_ct        <= '0;
            r_ovr       <= 1'b0;
        end else begin
            r_out_state <= w_out_next;
            if (w_cap) begin
                r_ct <= ct_data;
                r_oc <= '0;
            end else if (w_out_hs) begin
                r_ct <= r_ct >> BW;
                r_oc <= r_oc + 2'd1;
            end
            if (ct_capture && ct_busy)
                r_ovr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_shares_io_buffer.sv
// Scoreboard bench for aes_shares_io_buffer: expected blocks/beats are queued by the drivers and popped by a monitor.
module tb_aes_shares_io_buffer;
    localparam int D  = 2;
    localparam int BW = 32*D;
    localparam int KW = 128*D;

    logic          clk;
    logic          rst;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [KW-1:0] pt_data;
    logic          pt_valid;
    logic          pt_ready;
    logic [KW-1:0] ct_data;
    logic          ct_capture;
    logic          ct_busy;
    logic          ct_overrun;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    aes_shares_io_buffer #(.d(D)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ct_data(ct_data), .ct_capture(ct_capture), .ct_busy(ct_busy), .ct_overrun(ct_overrun),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [KW-1:0] exp_pt_q[$];
    logic [BW-1:0] exp_out_q[$];
    logic [BW-1:0] beat_acc[$];
    logic          exp_ovr = 1'b0;

    task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rnd_beat();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [KW-1:0] rnd_blk();
        logic [KW-1:0] r;
        for (int i = 0; i < KW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: byte j of beat k is state byte 4k+j; state byte i is the 8*D-bit group i of the block
    task automatic model_beat(input logic [BW-1:0] b);
        logic [KW-1:0] blk;
        logic [BW-1:0] bt;
        beat_acc.push_back(b);
        if (beat_acc.size() == 4) begin
            for (int i = 0; i < 16; i++) begin
                bt = beat_acc[i/4];
                blk[i*8*D +: 8*D] = bt[(i%4)*8*D +: 8*D];
            end
            exp_pt_q.push_back(blk);
            beat_acc.delete();
        end
    endtask

    task automatic send_beat(input logic [BW-1:0] b);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!ok && n < 60) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check("in_timeout", ok, 1);
        else     model_beat(b);
    endtask

    task automatic capture(input logic [KW-1:0] v);
        logic [BW-1:0] bt;
        ct_data    = v;
        ct_capture = 1'b1;
        if (exp_out_q.size() == 0) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) bt[j*8*D +: 8*D] = v[(4*k+j)*8*D +: 8*D];
                exp_out_q.push_back(bt);
            end
        end else begin
            exp_ovr = 1'b1;
        end
        @(posedge clk); #1;
        ct_capture = 1'b0;
    endtask

    task automatic pulse_pt();
        pt_ready = 1'b1;
        @(posedge clk); #1;
        pt_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; ct_capture = 1'b0; pt_ready = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        beat_acc.delete(); exp_pt_q.delete(); exp_out_q.delete(); exp_ovr = 1'b0;
        check("rst_pt_valid", pt_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_ct_busy", ct_busy, 0);
        check("rst_ct_overrun", ct_overrun, 0);
        check("rst_pt_data", pt_data, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        @(posedge clk); #1;
    endtask

    // Monitor: whenever an output is presented it must equal the head of its queue; a handshake pops it
    always @(negedge clk) begin
        if (!rst) begin
            if (pt_valid) begin
                if (exp_pt_q.size() == 0) check("pt_extra", pt_valid, 0);
                else begin
                    check("pt_data", pt_data, exp_pt_q[0]);
                    if (pt_ready) void'(exp_pt_q.pop_front());
                end
            end
            if (out_valid) begin
                if (exp_out_q.size() == 0) check("out_extra", out_valid, 0);
                else begin
                    check("out_data", out_data, exp_out_q[0]);
                    if (out_ready) void'(exp_out_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] bt;
        logic [KW-1:0] v;
        logic [15:0]   e16;
        int            seq[6];
        int            acc, t4, cyc;
        logic          hs;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; pt_ready = 1'b0;
        ct_data = '0; ct_capture = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // 1: block assembly and plaintext handshake
        send_beat(64'h0706050403020100);
        send_beat(64'h0F0E0D0C0B0A0908);
        send_beat(64'h1716151413121110);
        send_beat(64'h1F1E1D1C1B1A1918);
`ifndef AES_IO_PT_PREFETCH_EN
        check("t1_latency", pt_valid, 1);
        check("t1_in_ready_full", in_ready, 0);
`else
        @(posedge clk); #1;
        check("t1_latency", pt_valid, 1);
`endif
        for (int i = 0; i < 16; i++) begin
            e16 = {8'(2*i+1), 8'(2*i)};
            check("t1_byte", pt_data[16*i +: 16], e16);
        end
        repeat (3) @(posedge clk);
        #1;
        check("t1_hold_valid", pt_valid, 1);
        pt_ready = 1'b1;
`ifndef AES_IO_PT_PREFETCH_EN
        #1 check("t1_in_ready_hs", in_ready, 0);
`endif
        @(posedge clk); #1;
        pt_ready = 1'b0;
        check("t1_pt_valid_after", pt_valid, 0);
        check("t1_in_ready_after", in_ready, 1);

        // 2: ciphertext serialization with stalls
        for (int n = 0; n < 32; n++) v[8*n +: 8] = 8'(n);
        capture(v);
        seq[0] = 1; seq[1] = 0; seq[2] = 1; seq[3] = 1; seq[4] = 0; seq[5] = 1;
        for (int s = 0; s < 6; s++) begin
            out_ready = seq[s][0];
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("t2_out_valid_end", out_valid, 0);
        check("t2_ct_busy_end", ct_busy, 0);
        check("t2_beats_left", exp_out_q.size(), 0);
        check("t2_overrun", ct_overrun, 0);

        // 3: captures during beat 2 and on the final-beat cycle are dropped
        capture(rnd_blk());
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        capture(rnd_blk());
        capture(rnd_blk());
        check("t3_out_valid_end", out_valid, 0);
        check("t3_overrun", ct_overrun, exp_ovr);
        check("t3_overrun_set", ct_overrun, 1);
        capture(rnd_blk());
        repeat (6) @(posedge clk);
        #1;
        check("t3_overrun_held", ct_overrun, 1);
        check("t3_beats_left", exp_out_q.size(), 0);
        out_ready = 1'b0;

        // 4: reset in the middle of both transfers
        capture(rnd_blk());
        send_beat(rnd_beat());
        send_beat(rnd_beat());
        out_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();
        for (int k = 0; k < 4; k++) send_beat(rnd_beat());
        @(posedge clk); #1;
        check("t4_pt_valid", pt_valid, 1);
        pulse_pt();
        check("t4_pt_left", exp_pt_q.size(), 0);

        // 5: random concurrent traffic on both paths
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_beat(rnd_beat());
                end
            end
            begin
                repeat (300) begin
                    pt_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                pt_ready = 1'b0;
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    cyc = 0;
                    while (exp_out_q.size() != 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
                    capture(rnd_blk());
                    if ($urandom_range(0, 3) == 0) capture(rnd_blk());
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
            begin
                repeat (300) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b0;
            end
        join
        pt_ready = 1'b1; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        pt_ready = 1'b0; out_ready = 1'b0;
        check("t5_pt_left", exp_pt_q.size(), 0);
        check("t5_out_left", exp_out_q.size(), 0);
        check("t5_partial", beat_acc.size(), 0);
        check("t5_overrun", ct_overrun, exp_ovr);

`ifdef AES_IO_PT_PREFETCH_EN
        // 6: prefetch of a second block while the first is held
        do_reset();
        acc = 0; t4 = -1; cyc = 0;
        bt = rnd_beat(); in_data = bt; in_valid = 1'b1;
        while (acc < 8 && cyc < 60) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                model_beat(bt);
                acc++;
                if (acc == 4) t4 = cyc;
                bt = rnd_beat();
                in_data = bt;
            end
            if (t4 > 0 && cyc == t4)     check("t6_lat1", pt_valid, 0);
            if (t4 > 0 && cyc == t4 + 1) check("t6_lat2", pt_valid, 1);
        end
        in_valid = 1'b0;
        check("t6_beats", acc, 8);
        check("t6_in_ready_full", in_ready, 0);
        pulse_pt();
        check("t6_pt_valid_next", pt_valid, 1);
        check("t6_in_ready_back", in_ready, 1);
        pulse_pt();
        check("t6_pt_valid_end", pt_valid, 0);
        check("t6_pt_left", exp_pt_q.size(), 0);
`else
        acc = 0; t4 = 0; cyc = 0; hs = 1'b0; bt = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
